// File: rtl/lstm_train_ctrl_pkg.sv
// Shared types for the LSTM training sequencer: state encoding and sizing helpers.
package lstm_train_ctrl_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_LOAD_T = 3'd1,
      S_SHIFT  = 3'd2,
      S_COMP   = 3'd3,
      S_BP     = 3'd4,
      S_WR     = 3'd5,
      S_DONE   = 3'd6
   } state_e;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lstm_train_ctrl_if.sv
// Host-side handshake plus the control bus driven into the LSTM backprop array.
interface lstm_train_ctrl_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STEP_W = 4
);
   logic              i_start;
   logic [WIDTH-1:0]  i_label_base;
   logic [WIDTH-1:0]  i_cost;
   logic              o_sel;
   logic              o_load_in;
   logic              o_load_h;
   logic              o_load_bp;
   logic              o_load_t;
   logic [WIDTH-1:0]  o_addr_t;
   logic              o_wr;
   logic              o_busy;
   logic              o_done;
   logic [STEP_W-1:0] o_step;
   logic [WIDTH-1:0]  o_cost;

   modport master (
      output i_start, i_label_base, i_cost,
      input  o_sel, o_load_in, o_load_h, o_load_bp, o_load_t, o_addr_t,
             o_wr, o_busy, o_done, o_step, o_cost
   );

   modport slave (
      input  i_start, i_label_base, i_cost,
      output o_sel, o_load_in, o_load_h, o_load_bp, o_load_t, o_addr_t,
             o_wr, o_busy, o_done, o_step, o_cost
   );
endinterface

// File: rtl/lstm_train_ctrl_phase_cnt.sv
// Loadable up-counter with a terminal-count flag against a run-time terminal value.
module phase_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld_i,
   input  logic [W-1:0] ld_val_i,
   input  logic         inc_i,
   input  logic [W-1:0] term_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ld_i) begin
         cnt_d = ld_val_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/lstm_train_ctrl.sv
// Training sequencer: label load, NUM_ITERATIONS forward timesteps, backprop settle,
// single weight commit and cost capture, behind a start/busy/done handshake.
module lstm_train_ctrl
   import lstm_train_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned NUM            = 45,
   parameter int unsigned NUM_LSTM       = 8,
   parameter int unsigned NUM_ITERATIONS = 8,
   parameter int unsigned COMP_LAT       = 2,
   parameter int unsigned BP_LAT         = 4,
   parameter int unsigned STEP_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   lstm_train_ctrl_if.slave bus
);

   localparam int unsigned PH_MAX = max2(max2(NUM, NUM_LSTM), max2(COMP_LAT, BP_LAT));
   localparam int unsigned CNT_W  = cnt_width(PH_MAX);

   state_e             state_q;
   state_e             state_d;
   logic [WIDTH-1:0]   addr_q;
   logic [WIDTH-1:0]   addr_d;
   logic [WIDTH-1:0]   cost_q;
   logic [WIDTH-1:0]   cost_d;

   logic               cnt_ld;
   logic               cnt_inc;
   logic [CNT_W-1:0]   cnt_term;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_tc;
   logic               step_ld;
   logic               step_inc;
   logic [STEP_W-1:0]  step;
   logic               step_tc;

   phase_cnt #(.W(CNT_W)) u_phase_cnt (
      .clk      (clk),
      .rst      (rst),
      .ld_i     (cnt_ld),
      .ld_val_i ('0),
      .inc_i    (cnt_inc),
      .term_i   (cnt_term),
      .cnt_o    (cnt),
      .tc_o     (cnt_tc)
   );

   // step_tc flags the last timestep, so the increment out of it lands on NUM_ITERATIONS.
   phase_cnt #(.W(STEP_W)) u_step_cnt (
      .clk      (clk),
      .rst      (rst),
      .ld_i     (step_ld),
      .ld_val_i ('0),
      .inc_i    (step_inc),
      .term_i   (STEP_W'(NUM_ITERATIONS - 1)),
      .cnt_o    (step),
      .tc_o     (step_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cost_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cost_q  <= cost_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cost_d   = cost_q;
      cnt_ld   = 1'b0;
      cnt_inc  = 1'b0;
      step_ld  = 1'b0;
      step_inc = 1'b0;
      cnt_term = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               state_d = S_LOAD_T;
               addr_d  = bus.i_label_base;
               cnt_ld  = 1'b1;
               step_ld = 1'b1;
            end
         end
         S_LOAD_T: begin
            cnt_term = CNT_W'(NUM_LSTM - 1);
            if (cnt_tc) begin
               state_d = S_SHIFT;
               cnt_ld  = 1'b1;
            end else begin
               cnt_inc = 1'b1;
               addr_d  = addr_q + WIDTH'(1);
            end
         end
         S_SHIFT: begin
            cnt_term = CNT_W'(NUM - 1);
            if (cnt_tc) begin
               state_d = S_COMP;
               cnt_ld  = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_COMP: begin
            cnt_term = CNT_W'(COMP_LAT - 1);
            if (cnt_tc) begin
               state_d  = step_tc ? S_BP : S_SHIFT;
               cnt_ld   = 1'b1;
               step_inc = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_BP: begin
            cnt_term = CNT_W'(BP_LAT - 1);
            if (cnt_tc) begin
               state_d = S_WR;
               cnt_ld  = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_WR: begin
            state_d = S_DONE;
            cost_d  = bus.i_cost;
         end
         S_DONE: begin
            state_d = S_IDLE;
            step_ld = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes decode only registered state and counters.
   always_comb begin
      bus.o_sel     = 1'b0;
      bus.o_load_in = 1'b0;
      bus.o_load_h  = 1'b0;
      bus.o_load_bp = 1'b0;
      bus.o_load_t  = 1'b0;
      bus.o_wr      = 1'b0;
      bus.o_done    = 1'b0;
      bus.o_busy    = (state_q != S_IDLE);
      bus.o_addr_t  = addr_q;
      bus.o_step    = step;
      bus.o_cost    = cost_q;
      case (state_q)
         S_LOAD_T: bus.o_load_t = 1'b1;
         S_SHIFT: begin
            bus.o_sel     = (step != '0);
            bus.o_load_in = cnt_tc;
         end
         S_COMP: begin
            bus.o_sel     = (step != '0);
            bus.o_load_h  = cnt_tc;
            bus.o_load_bp = cnt_tc;
         end
         S_WR:    bus.o_wr   = 1'b1;
         S_DONE:  bus.o_done = 1'b1;
         default: ;
      endcase
   end

endmodule
